// File: rtl/gpu_frame_sequencer.sv
// gpu_frame_sequencer: host-driven frame sequencer (conversion, then draw) with clear path and wait timeouts
module gpu_frame_sequencer #(
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic       cmd_clear,
    input  logic       in_finsh_serial_parallel_conv,
    input  logic       in_triangle_finsh,
    input  logic       in_line_drawin_finsh,
    input  logic       in_clear_finsh,
    output logic       out_start_serial_parallel_conv,
    output logic       out_start_writting,
    output logic       out_start_clear,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic [7:0] frame_count
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CONV       = 3'd1;
    localparam logic [2:0] WAIT_CONV  = 3'd2;
    localparam logic [2:0] WAIT_DRAW  = 3'd3;
    localparam logic [2:0] CLEAR      = 3'd4;
    localparam logic [2:0] WAIT_CLEAR = 3'd5;
    localparam logic [2:0] DONE       = 3'd6;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tri_q, tri_d, line_q, line_d;
    logic        from_draw_q, from_draw_d;
    logic        err_q, err_d;
    logic [7:0]  count_q, count_d;
    logic        tri_seen, line_seen, in_wait, exit_ok, tmo;

    // next-state, wait counter and sticky draw-finish bookkeeping
    always_comb begin
        tri_seen    = tri_q | in_triangle_finsh;
        line_seen   = line_q | in_line_drawin_finsh;
        in_wait     = (state_q == WAIT_CONV) || (state_q == WAIT_DRAW) || (state_q == WAIT_CLEAR);
        exit_ok     = ((state_q == WAIT_CONV) && in_finsh_serial_parallel_conv) ||
                      ((state_q == WAIT_DRAW) && tri_seen && line_seen) ||
                      ((state_q == WAIT_CLEAR) && in_clear_finsh);
        tmo         = in_wait && !exit_ok && (cnt_q == LAST);
        state_d     = IDLE;
        case (state_q)
            IDLE:       state_d = cmd_clear ? CLEAR : (cmd_start ? CONV : IDLE);
            CONV:       state_d = WAIT_CONV;
            WAIT_CONV:  state_d = exit_ok ? WAIT_DRAW : (tmo ? IDLE : WAIT_CONV);
            WAIT_DRAW:  state_d = exit_ok ? DONE : (tmo ? IDLE : WAIT_DRAW);
            CLEAR:      state_d = WAIT_CLEAR;
            WAIT_CLEAR: state_d = exit_ok ? DONE : (tmo ? IDLE : WAIT_CLEAR);
            default:    state_d = IDLE;
        endcase
        cnt_d       = (in_wait && (state_d == state_q)) ? cnt_q + 16'd1 : 16'd0;
        tri_d       = (state_q == WAIT_DRAW) && tri_seen;
        line_d      = (state_q == WAIT_DRAW) && line_seen;
        from_draw_d = (state_q == WAIT_DRAW) && (state_d == DONE);
        err_d       = err_q | tmo;
        count_d     = count_q + {7'd0, (state_q == DONE) && from_draw_q};
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            tri_q       <= 1'b0;
            line_q      <= 1'b0;
            from_draw_q <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tri_q       <= tri_d;
            line_q      <= line_d;
            from_draw_q <= from_draw_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_start_serial_parallel_conv = (state_q == CONV);
    assign out_start_writting             = (state_q == WAIT_DRAW);
    assign out_start_clear                = (state_q == CLEAR);
    assign busy                           = (state_q != IDLE);
    assign frame_done                     = (state_q == DONE);
    assign timeout_err                    = err_q;
    assign frame_count                    = count_q;
endmodule

// File: doc/gpu_frame_sequencer.md
GPU_FRAME_SEQUENCER -- requirements
Module: gpu_frame_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095, meaning the maximum cycles spent in any WAIT_* state before abort (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cmd_start, input, 1, a host request to run one frame (conversion, then draw).
REQ-005 SHALL have port cmd_clear, input, 1, a host request to clear the frame buffer.
REQ-006 SHALL have port in_finsh_serial_parallel_conv, input, 1, serial-to-parallel conversion complete.
REQ-007 SHALL have port in_triangle_finsh, input, 1, triangle engine complete.
REQ-008 SHALL have port in_line_drawin_finsh, input, 1, line engine complete.
REQ-009 SHALL have port in_clear_finsh, input, 1, clear engine complete.
REQ-010 SHALL have port out_start_serial_parallel_conv, output, 1, one-cycle conversion start pulse.
REQ-011 SHALL have port out_start_writting, output, 1, draw enable, held high throughout WAIT_DRAW.
REQ-012 SHALL have port out_start_clear, output, 1, one-cycle clear start pulse.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse on successful completion of a frame or a clear.
REQ-015 SHALL have port timeout_err, output, 1, sticky abort flag.
REQ-016 SHALL have port frame_count, output, 8, count of completed frames.

Function
REQ-017 SHALL implement the states IDLE, CONV, WAIT_CONV, WAIT_DRAW, CLEAR, WAIT_CLEAR and DONE.
REQ-018 SHALL, in IDLE, go to CLEAR if cmd_clear=1, else to CONV if cmd_start=1; cmd_clear wins when both are high.
REQ-019 SHALL ignore cmd_start and cmd_clear in every state other than IDLE; they are not queued.
REQ-020 SHALL drive out_start_serial_parallel_conv=1 for exactly the one cycle spent in CONV, then go to WAIT_CONV.
REQ-021 SHALL, in WAIT_CONV, go to WAIT_DRAW on the first cycle in which in_finsh_serial_parallel_conv=1.
REQ-022 SHALL drive out_start_writting=1 in every WAIT_DRAW cycle and 0 in all other states.
REQ-023 SHALL, in WAIT_DRAW, latch each of in_triangle_finsh and in_line_drawin_finsh into a sticky bit, because the two finishes may arrive in any order or in the same cycle.
REQ-024 SHALL leave WAIT_DRAW for DONE in the cycle when both draw finishes are seen (sticky bit or live input); the sticky bits are cleared on entry to WAIT_DRAW.
REQ-025 SHALL drive out_start_clear=1 for exactly the one cycle spent in CLEAR, then go to WAIT_CLEAR.
REQ-026 SHALL, in WAIT_CLEAR, go to DONE on in_clear_finsh=1.
REQ-027 SHALL, in DONE, pulse frame_done=1 for one cycle, then return to IDLE.
REQ-028 SHALL increment frame_count by 1 in DONE only when DONE was entered from WAIT_DRAW; it wraps from 255 to 0.
REQ-029 SHALL run a 16-bit wait counter that is zeroed on entry to each WAIT_* state and increments once per cycle in that state.
REQ-030 SHALL, when the wait counter reaches TIMEOUT-1 and the exit condition is false in that cycle, set timeout_err=1 and go to IDLE next cycle, with no frame_done and no frame_count increment.
REQ-031 SHALL give a finish arriving in the same cycle as the timeout priority, so that the transition is taken normally.
REQ-032 SHALL keep timeout_err high until rst; it does not block new commands.
REQ-033 SHALL ignore finish inputs that arrive outside their WAIT state.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, force state=IDLE and clear all of the following: every output, the wait counter, frame_count, timeout_err and the sticky bits.
REQ-035 SHALL give rst priority over all inputs, including mid-operation; a reset in WAIT_DRAW drops out_start_writting to 0 on the next cycle.

Verification
REQ-036 Frame: cmd_start pulse, conv finish after 5 cycles, tri finish at +3, line finish at +7 -> one conv pulse, out_start_writting high until the line finish, frame_done once, frame_count=1.
REQ-037 Same-cycle cases: both draw finishes in the same cycle -> DONE next cycle; cmd_start and cmd_clear together in IDLE -> a clear pulse only, no conv pulse, frame_count unchanged.
REQ-038 Timeout: TIMEOUT=8, conv finish never arrives -> timeout_err=1 eight cycles after entering WAIT_CONV, busy=0, no frame_done; a following frame completes with timeout_err still 1.
REQ-039 Wrap: 256 completed frames -> frame_count=0; cmd_start during WAIT_DRAW -> no extra frame.
REQ-040 Reset mid-draw: rst in WAIT_DRAW -> all outputs 0 next cycle; a stale line finish afterwards -> no effect.
